mult_seq: RTL and testbench

- Sequential shift-and-add multiplier. Consumes a 32-bit ripple adder as its per-iteration accumulate datapath.
- Sits beside the ALU in the execute stage. Accepts operands on a start pulse, iterates one bit per clock, and returns a 2*WIDTH-bit product with a one-cycle done pulse.
- Latency is fixed and independent of operand values.

---
 rtl/mult_pkg.sv | 12 +
 rtl/mul_add32.sv | 20 ++
 rtl/mult_seq.sv | 114 +++++++++++
 tb/tb_mult_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier.
package mult_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, NEG} state_e;

  // Iteration-counter width for a given operand width (never zero bits).
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/mul_add32.sv
// Ripple-carry adder with carry out; accumulate datapath of mult_seq.
module mul_add32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/mult_seq.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// MULT_SEQ_SIGNED_EN adds signed_op and a one-edge NEG fix-up state.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SEQ_SIGNED_EN
  input  logic               signed_op,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   add_b, sum;
  logic               cout;
  logic [2*WIDTH-1:0] p_next;

`ifdef MULT_SEQ_SIGNED_EN
  logic sgn, neg;
  // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign a_mag = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  assign add_b = p[0] ? mcand : '0;

  mul_add32 #(.WIDTH(WIDTH)) u_add (
    .a    (p[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .sum  (sum),
    .cout (cout)
  );

  // Carry becomes the new top bit, so the 2W-bit result is always exact.
  assign p_next = {cout, sum, p[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      p       <= '0;
      cnt     <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      sgn     <= 1'b0;
      neg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand <= a_mag;
          p     <= {{WIDTH{1'b0}}, b_mag};
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
`ifdef MULT_SEQ_SIGNED_EN
          sgn   <= signed_op;
          neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
`ifdef MULT_SEQ_SIGNED_EN
            if (sgn) begin
              state <= NEG;
            end else begin
              product <= p_next;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
`else
            product <= p_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
`endif
          end
        end
`ifdef MULT_SEQ_SIGNED_EN
        NEG: begin
          product <= neg ? (~p + 1'b1) : p;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq (signed cases under MULT_SEQ_SIGNED_EN).
module tb_mult_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;
`ifdef MULT_SEQ_SIGNED_EN
  logic        signed_op;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef MULT_SEQ_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  // Pulse start for one edge, then count edges to done and busy samples before it.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output int lat, output int bc);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    lat = 0; bc = 0;
    if (busy) bc++;
    while (lat < 100) begin
      @(posedge clk); lat++;
      #1;
      if (done) break;
      if (busy) bc++;
    end
  endtask

  task automatic test_reset;
    int nd;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL rst_product got %h exp 0", product); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      errors++; $display("FAIL rst_async got busy=%b done=%b product=%h exp 0/0/0", busy, done, product);
    end
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    repeat (40) begin @(posedge clk); #1; if (done) nd++; end
    checks++; if (nd !== 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", nd); end
  endtask

  task automatic test_basic;
    int lat, bc;
    run_op(32'd3, 32'd5, lat, bc);
    checks++; if (lat !== 32) begin errors++; $display("FAIL basic_lat got %0d exp 32", lat); end
    checks++; if (product !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL basic_product got %h exp f", product); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 32", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b exp 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done); end
    checks++; if (product !== 64'd15) begin errors++; $display("FAIL basic_hold got %h exp f", product); end
  endtask

  task automatic test_abort;
    int nd;
    @(negedge clk); a = 32'd100; b = 32'd100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (product !== 64'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_reset got product=%h busy=%b exp 0/0", product, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    repeat (40) begin @(posedge clk); #1; if (done) nd++; end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", nd); end
  endtask

  task automatic test_carry;
    int lat, bc;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checks++; if (product !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL carry_product got %h exp fffffffe00000001", product); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL carry_lat got %0d exp 32", lat); end
  endtask

  task automatic test_zero;
    int lat, bc;
    run_op(32'd0, 32'h1234_5678, lat, bc);
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL zero_product got %h exp 0", product); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL zero_lat got %0d exp 32", lat); end
  endtask

  task automatic test_back_to_back;
    int lat, nd;
    @(negedge clk); a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1 a = 32'd1; b = 32'd1;
    lat = 0; nd = 0;
    while (lat < 100) begin @(posedge clk); lat++; #1; if (done) break; end
    checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_lat1 got %0d exp 32", lat); end
    checks++; if (product !== 64'd63) begin errors++; $display("FAIL b2b_product1 got %0d exp 63", product); end
    a = 32'd7; b = 32'd0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got done=%b busy=%b exp 0/1", done, busy);
    end
    start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); lat++; #1;
      if (lat == 16) begin
        checks++; if (product !== 64'd63) begin errors++; $display("FAIL b2b_hold got %0d exp 63", product); end
      end
      if (done) break;
    end
    checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_lat2 got %0d exp 32", lat); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL b2b_product2 got %h exp 0", product); end
    repeat (40) begin @(posedge clk); #1; if (done) nd++; end
    checks++; if (nd !== 0) begin errors++; $display("FAIL b2b_extra_done got %0d exp 0", nd); end
  endtask

`ifdef MULT_SEQ_SIGNED_EN
  task automatic test_signed;
    int lat, bc;
    signed_op = 1'b1;
    run_op(32'hFFFF_FFFD, 32'd5, lat, bc);
    checks++; if (product !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL sgn_neg_product got %h exp fffffffffffffff1", product); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL sgn_lat got %0d exp 33", lat); end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++; if (product !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL sgn_min_product got %h exp 80000000", product); end
    signed_op = 1'b0;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++; if (product !== 64'h7FFF_FFFF_8000_0000) begin errors++; $display("FAIL sgn_off_product got %h exp 7fffffff80000000", product); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL sgn_off_lat got %0d exp 32", lat); end
  endtask
`endif

  initial begin
`ifdef MULT_SEQ_SIGNED_EN
    signed_op = 1'b0;
`endif
    test_reset;
    test_basic;
    test_abort;
    test_carry;
    test_zero;
    test_back_to_back;
`ifdef MULT_SEQ_SIGNED_EN
    test_signed;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
